signal_sequencer: RTL and testbench
===================================

SIGNAL_SEQUENCER -- requirements
Module: signal_sequencer

Interface
REQ-001 SHALL have parameter ROM_SIG_WIDTH, default 10, meaning the ROM word width.
REQ-002 SHALL have parameter SIG_ADDRS_WIDTH, default 10, meaning the ROM address width.
REQ-003 SHALL have parameter REP_WIDTH, default 3, meaning the repeat-count field width; CTRL_WIDTH = ROM_SIG_WIDTH-1-REP_WIDTH.
REQ-004 SHALL have port clk_i  input  1  system clock, rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset; one clock, reset asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  begin a sequence, sampled in IDLE only.
REQ-007 SHALL have port base_addr_i  input  SIG_ADDRS_WIDTH  first ROM address, captured with start_i.
REQ-008 SHALL have port stall_i  input  1  downstream backpressure, freezes the sequencer.
REQ-009 SHALL have port addrs_rom_signal_o  output  SIG_ADDRS_WIDTH  ROM address.
REQ-010 SHALL have port rd_rom_signals_ld_o  output  1  ROM read enable.
REQ-011 SHALL have port rom_signals_data_i  input  ROM_SIG_WIDTH  combinational ROM data, same cycle as address.
REQ-012 SHALL have port signals_o  output  CTRL_WIDTH  registered control vector to the array.
REQ-013 SHALL have port sig_valid_o, busy_o, done_o  output  1 each  vector valid / sequence active / completion pulse.

Function
REQ-014 SHALL decode the ROM word as: bit[ROM_SIG_WIDTH-1] = last flag; the next REP_WIDTH bits = repeat count R; the low CTRL_WIDTH bits = control.
REQ-015 SHALL implement states IDLE, FETCH, RUN, and DONE.
REQ-016 SHALL, in IDLE with start_i=1, capture base_addr_i into the address register and move to FETCH; start_i outside IDLE SHALL be ignored.
REQ-017 SHALL, in FETCH, assert rd_rom_signals_ld_o, drive the address register, and register the word: signals_o=control, rep_cnt=R, last_q=flag, sig_valid_o=1; address +1; next state RUN.
REQ-018 SHALL assert the first valid signals_o 2 cycles after the start_i cycle.
REQ-019 SHALL present each word on signals_o for exactly R+1 non-stalled cycles.
REQ-020 SHALL, in RUN with stall_i=0 and rep_cnt>0, decrement rep_cnt and hold signals_o.
REQ-021 SHALL, in RUN with stall_i=0, rep_cnt=0 and last_q=0, read the next word in the same cycle with no bubble (as in REQ-017).
REQ-022 SHALL, in RUN with stall_i=0, rep_cnt=0 and last_q=1, clear sig_valid_o and move to DONE.
REQ-023 SHALL, while stall_i=1 in FETCH or RUN, hold all state, keep rd_rom_signals_ld_o=0 and keep signals_o/sig_valid_o unchanged; FETCH SHALL resume after the stall.
REQ-024 SHALL pulse done_o for one cycle in DONE, then return to IDLE.
REQ-025 SHALL drive busy_o=1 in FETCH and RUN, else 0.
REQ-026 SHALL wrap the address modulo 2^SIG_ADDRS_WIDTH (all-ones+1 = 0).
REQ-027 SHALL drive rd_rom_signals_ld_o=0 whenever no read is required.

Reset
REQ-028 SHALL, on rst_n_i=0 at any time, including mid-sequence, immediately enter IDLE and clear the address register, rep_cnt, last_q, signals_o, sig_valid_o, done_o, busy_o and rd_rom_signals_ld_o to 0.

Configuration
REQ-029 SHALL, with SIG_SEQ_LOOP_EN defined, add an input loop_i (1 bit): a last word with loop_i=1 reloads the captured base address and continues without a bubble, and the sequence ends at the next last word seen with loop_i=0; without the macro, the port SHALL be absent and last always ends the sequence.

Verification
REQ-030 SHALL cover a 2-word sequence: base=0x004 with ROM[4]=0b0_010_000101 and ROM[5]=0b1_000_110000 -> signals_o is 0x05 for 3 cycles, then 0x30 for 1 cycle; done_o pulses 1 cycle later.
REQ-031 SHALL cover a stall: stall_i=1 for 4 cycles during word 0x05 -> 0x05 is held for 3+4 cycles, and there are no ROM reads during the stall.
REQ-032 SHALL cover wrap-around: base=0x3FF with ROM[0x3FF] having last=0 -> the next read address is 0x000.
REQ-033 SHALL cover reset mid-operation: rst_n_i low while in RUN -> all outputs are 0 immediately, the block is in IDLE, and a new start_i restarts cleanly.
REQ-034 SHALL cover start_i pulsed while busy_o=1 -> the pulse is ignored and the sequence is unchanged.
REQ-035 SHALL cover, with SIG_SEQ_LOOP_EN defined and loop_i=1 for 2 passes over the REQ-030 ROM -> the pattern 0x05 x3, 0x30 x1 is emitted twice contiguously, followed by a single done_o pulse.

Source files
------------

// File: rtl/signal_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : signal_sequencer
// Brief    : Walks a ROM of {last, repeat, control} words and holds each
//            control vector for repeat+1 non-stalled cycles. Defining
//            SIG_SEQ_LOOP_EN adds loop_i to restart at the base address.
// Revision : 1.0
// ============================================================================

module signal_sequencer #(
    parameter int  ROM_SIG_WIDTH   = 10,
    parameter int  SIG_ADDRS_WIDTH = 10,
    parameter int  REP_WIDTH       = 3,
    localparam int CTRL_WIDTH      = ROM_SIG_WIDTH - 1 - REP_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [SIG_ADDRS_WIDTH-1:0] base_addr_i,
    input  logic                       stall_i,
`ifdef SIG_SEQ_LOOP_EN
    input  logic                       loop_i,
`endif
    output logic [SIG_ADDRS_WIDTH-1:0] addrs_rom_signal_o,
    output logic                       rd_rom_signals_ld_o,
    input  logic [ROM_SIG_WIDTH-1:0]   rom_signals_data_i,
    output logic [CTRL_WIDTH-1:0]      signals_o,
    output logic                       sig_valid_o,
    output logic                       busy_o,
    output logic                       done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    logic [SIG_ADDRS_WIDTH-1:0] r_addr;
    logic [REP_WIDTH-1:0]       r_rep_cnt;
    logic                       r_last_q;

    logic                       w_word_last;
    logic [REP_WIDTH-1:0]       w_word_rep;
    logic [CTRL_WIDTH-1:0]      w_word_ctrl;
    logic                       w_rep_zero;
    logic                       w_reload;
    logic                       w_fetch;
    logic [SIG_ADDRS_WIDTH-1:0] w_rd_addr;

    assign w_word_last = rom_signals_data_i[ROM_SIG_WIDTH-1];
    assign w_word_rep  = rom_signals_data_i[ROM_SIG_WIDTH-2 -: REP_WIDTH];
    assign w_word_ctrl = rom_signals_data_i[CTRL_WIDTH-1:0];
    assign w_rep_zero  = (r_rep_cnt == '0);

`ifdef SIG_SEQ_LOOP_EN
    logic [SIG_ADDRS_WIDTH-1:0] r_base;

    // Looping presents the base address combinationally so the reload
    // costs no bubble cycle.
    assign w_reload  = (r_state == S_RUN) && w_rep_zero && r_last_q && loop_i;
    assign w_rd_addr = w_reload ? r_base : r_addr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_base <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_base <= base_addr_i;
        end
    end
`else
    assign w_reload  = 1'b0;
    assign w_rd_addr = r_addr;
`endif

    assign w_fetch = !stall_i &&
                     ((r_state == S_FETCH) ||
                      ((r_state == S_RUN) && w_rep_zero && (!r_last_q || w_reload)));

    assign rd_rom_signals_ld_o = w_fetch;
    assign addrs_rom_signal_o  = w_rd_addr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rep_cnt   <= '0;
            r_last_q    <= 1'b0;
            signals_o   <= '0;
            sig_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        r_addr  <= base_addr_i;
                        busy_o  <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH, S_RUN: begin
                    if (w_fetch) begin
                        signals_o   <= w_word_ctrl;
                        r_rep_cnt   <= w_word_rep;
                        r_last_q    <= w_word_last;
                        sig_valid_o <= 1'b1;
                        r_addr      <= w_rd_addr + SIG_ADDRS_WIDTH'(1);
                        r_state     <= S_RUN;
                    end else if (!stall_i && (r_state == S_RUN)) begin
                        if (!w_rep_zero) begin
                            r_rep_cnt <= r_rep_cnt - REP_WIDTH'(1);
                        end else begin
                            sig_valid_o <= 1'b0;
                            busy_o      <= 1'b0;
                            done_o      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_signal_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_signal_sequencer
// Brief    : Directed self-checking bench for signal_sequencer.
// Revision : 1.0
// ============================================================================

module tb_signal_sequencer;

    localparam int AW = 10;
    localparam int RW = 10;
    localparam int CW = 6;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic          stall_i;
    logic [AW-1:0] addrs_rom_signal_o;
    logic          rd_rom_signals_ld_o;
    logic [RW-1:0] rom_signals_data_i;
    logic [CW-1:0] signals_o;
    logic          sig_valid_o;
    logic          busy_o;
    logic          done_o;
`ifdef SIG_SEQ_LOOP_EN
    logic          loop_i;
`endif

    logic [RW-1:0] rom [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    assign rom_signals_data_i = rom[addrs_rom_signal_o];

    signal_sequencer #(
        .ROM_SIG_WIDTH   (RW),
        .SIG_ADDRS_WIDTH (AW),
        .REP_WIDTH       (3)
    ) dut (
`ifdef SIG_SEQ_LOOP_EN
        .loop_i              (loop_i),
`endif
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .start_i             (start_i),
        .base_addr_i         (base_addr_i),
        .stall_i             (stall_i),
        .addrs_rom_signal_o  (addrs_rom_signal_o),
        .rd_rom_signals_ld_o (rd_rom_signals_ld_o),
        .rom_signals_data_i  (rom_signals_data_i),
        .signals_o           (signals_o),
        .sig_valid_o         (sig_valid_o),
        .busy_o              (busy_o),
        .done_o              (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Signals are only meaningful while valid, the address only while reading.
    task automatic outs(input string tag, input logic v, input logic [CW-1:0] s,
                        input logic rd, input logic [AW-1:0] a,
                        input logic b, input logic d);
        chk({tag, ".valid"}, 32'(sig_valid_o), 32'(v));
        if (v) chk({tag, ".sig"}, 32'(signals_o), 32'(s));
        chk({tag, ".rd"}, 32'(rd_rom_signals_ld_o), 32'(rd));
        if (rd) chk({tag, ".addr"}, 32'(addrs_rom_signal_o), 32'(a));
        chk({tag, ".busy"}, 32'(busy_o), 32'(b));
        chk({tag, ".done"}, 32'(done_o), 32'(d));
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
        rom[10'h004] = 10'b0_010_000101;
        rom[10'h005] = 10'b1_000_110000;
        rom[10'h3FF] = 10'b0_000_010001;
        rom[10'h000] = 10'b1_000_100010;

        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        stall_i     = 1'b0;
        base_addr_i = '0;
`ifdef SIG_SEQ_LOOP_EN
        loop_i      = 1'b0;
`endif
        cyc();
        cyc();
        chk("rst.sig",   32'(signals_o), 32'h0);
        chk("rst.addr",  32'(addrs_rom_signal_o), 32'h0);
        outs("rst", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        rst_n_i = 1'b1;

        // Two-word sequence from base 0x004
        start_i = 1'b1; base_addr_i = 10'h004;
        cyc(); start_i = 1'b0;
        outs("t1.fetch", 1'b0, '0,    1'b1, 10'h004, 1'b1, 1'b0);
        cyc(); outs("t1.w0a", 1'b1, 6'h05, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t1.w0b", 1'b1, 6'h05, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t1.w0c", 1'b1, 6'h05, 1'b1, 10'h005, 1'b1, 1'b0);
        cyc(); outs("t1.w1",  1'b1, 6'h30, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t1.done", 1'b0, '0,   1'b0, '0,      1'b0, 1'b1);
        cyc(); outs("t1.idle", 1'b0, '0,   1'b0, '0,      1'b0, 1'b0);

        // Stall for 4 cycles during word 0x05, starting on its read cycle
        start_i = 1'b1; base_addr_i = 10'h004;
        cyc(); start_i = 1'b0;
        outs("t2.fetch", 1'b0, '0, 1'b1, 10'h004, 1'b1, 1'b0);
        cyc(); outs("t2.w0a", 1'b1, 6'h05, 1'b0, '0, 1'b1, 1'b0);
        cyc(); outs("t2.w0b", 1'b1, 6'h05, 1'b0, '0, 1'b1, 1'b0);
        cyc(); stall_i = 1'b1; #1;
        outs("t2.stall0", 1'b1, 6'h05, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(); outs("t2.stall", 1'b1, 6'h05, 1'b0, '0, 1'b1, 1'b0);
        end
        cyc(); stall_i = 1'b0; #1;
        outs("t2.resume", 1'b1, 6'h05, 1'b1, 10'h005, 1'b1, 1'b0);
        cyc(); outs("t2.w1",   1'b1, 6'h30, 1'b0, '0, 1'b1, 1'b0);
        cyc(); outs("t2.done", 1'b0, '0,    1'b0, '0, 1'b0, 1'b1);
        cyc(); outs("t2.idle", 1'b0, '0,    1'b0, '0, 1'b0, 1'b0);

        // Address wrap from 0x3FF, with a one-cycle stall in FETCH
        start_i = 1'b1; base_addr_i = 10'h3FF;
        cyc(); start_i = 1'b0; stall_i = 1'b1; #1;
        outs("t3.fstall", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        cyc(); stall_i = 1'b0; #1;
        outs("t3.fetch", 1'b0, '0, 1'b1, 10'h3FF, 1'b1, 1'b0);
        cyc(); outs("t3.wrap", 1'b1, 6'h11, 1'b1, 10'h000, 1'b1, 1'b0);
        cyc(); outs("t3.w1",   1'b1, 6'h22, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t3.done", 1'b0, '0,    1'b0, '0,      1'b0, 1'b1);
        cyc(); outs("t3.idle", 1'b0, '0,    1'b0, '0,      1'b0, 1'b0);

        // Asynchronous reset while in RUN
        start_i = 1'b1; base_addr_i = 10'h004;
        cyc(); start_i = 1'b0;
        cyc(); outs("t4.w0a", 1'b1, 6'h05, 1'b0, '0, 1'b1, 1'b0);
        #2; rst_n_i = 1'b0; #1;
        chk("t4.rst.sig",  32'(signals_o), 32'h0);
        chk("t4.rst.addr", 32'(addrs_rom_signal_o), 32'h0);
        outs("t4.rst", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        cyc(); rst_n_i = 1'b1;
        cyc(); outs("t4.idle", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        // Clean restart; a start pulse while busy must be ignored
        start_i = 1'b1; base_addr_i = 10'h004;
        cyc(); start_i = 1'b0;
        outs("t5.fetch", 1'b0, '0, 1'b1, 10'h004, 1'b1, 1'b0);
        cyc(); outs("t5.w0a", 1'b1, 6'h05, 1'b0, '0, 1'b1, 1'b0);
        start_i = 1'b1; base_addr_i = 10'h3FF;
        cyc(); start_i = 1'b0; base_addr_i = '0;
        outs("t5.w0b", 1'b1, 6'h05, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t5.w0c", 1'b1, 6'h05, 1'b1, 10'h005, 1'b1, 1'b0);
        cyc(); outs("t5.w1",  1'b1, 6'h30, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t5.done", 1'b0, '0,   1'b0, '0,      1'b0, 1'b1);
        cyc(); outs("t5.idle", 1'b0, '0,   1'b0, '0,      1'b0, 1'b0);

`ifdef SIG_SEQ_LOOP_EN
        // Two contiguous passes, ended by clearing loop_i during pass two
        loop_i = 1'b1;
        start_i = 1'b1; base_addr_i = 10'h004;
        cyc(); start_i = 1'b0;
        outs("t6.fetch", 1'b0, '0, 1'b1, 10'h004, 1'b1, 1'b0);
        cyc(); outs("t6.p1w0a", 1'b1, 6'h05, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t6.p1w0b", 1'b1, 6'h05, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t6.p1w0c", 1'b1, 6'h05, 1'b1, 10'h005, 1'b1, 1'b0);
        cyc(); outs("t6.p1w1",  1'b1, 6'h30, 1'b1, 10'h004, 1'b1, 1'b0);
        loop_i = 1'b0;
        cyc(); outs("t6.p2w0a", 1'b1, 6'h05, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t6.p2w0b", 1'b1, 6'h05, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t6.p2w0c", 1'b1, 6'h05, 1'b1, 10'h005, 1'b1, 1'b0);
        cyc(); outs("t6.p2w1",  1'b1, 6'h30, 1'b0, '0,      1'b1, 1'b0);
        cyc(); outs("t6.done",  1'b0, '0,    1'b0, '0,      1'b0, 1'b1);
        cyc(); outs("t6.idle",  1'b0, '0,    1'b0, '0,      1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
